// File: rtl/leiwand_rv32_wb_arbiter.sv
// Round-robin, CYC-locked arbiter letting two pipelined Wishbone masters share one slave port.
// A watchdog aborts cycles the slave never acknowledges and reports err to the owning master.
module leiwand_rv32_wb_arbiter #(
  parameter int MEM_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [MEM_WIDTH-1:0] m0_addr,
  input  logic [MEM_WIDTH-1:0] m0_data_out,
  output logic [MEM_WIDTH-1:0] m0_data_in,
  output logic                 m0_ack,
  output logic                 m0_stall,
  output logic                 m0_err,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [MEM_WIDTH-1:0] m1_addr,
  input  logic [MEM_WIDTH-1:0] m1_data_out,
  output logic [MEM_WIDTH-1:0] m1_data_in,
  output logic                 m1_ack,
  output logic                 m1_stall,
  output logic                 m1_err,
  output logic                 s_cyc,
  output logic                 s_stb,
  output logic                 s_we,
  output logic [MEM_WIDTH-1:0] s_addr,
  output logic [MEM_WIDTH-1:0] s_data_out,
  input  logic [MEM_WIDTH-1:0] s_data_in,
  input  logic                 s_ack,
  input  logic                 s_stall,
  output logic [2:0]           dbg_state
);

  // Handshake: a request transfers on a cycle with stb=1 and stall=0; ack returns
  // its response later. Acks are routed purely by the current grant owner.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT0  = 3'd1,
    GRANT1  = 3'd2,
    ERR     = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic [15:0] to_cnt, to_cnt_nxt;
  logic        own_cyc;

  // last_grant doubles as the owner while in GRANTx, ERR and RECOVER
  assign own_cyc   = last_grant ? m1_cyc : m0_cyc;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      to_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      to_cnt     <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    to_cnt_nxt     = to_cnt;
    case (state)
      IDLE: begin
        to_cnt_nxt = '0;
        if (m0_cyc && (!m1_cyc || last_grant)) begin
          state_nxt      = GRANT0;
          last_grant_nxt = 1'b0;
        end else if (m1_cyc) begin
          state_nxt      = GRANT1;
          last_grant_nxt = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (!own_cyc) begin
          state_nxt  = IDLE;
          to_cnt_nxt = '0;
        end else if (s_ack) begin
          to_cnt_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
          state_nxt  = ERR;
          to_cnt_nxt = '0;
        end else begin
          to_cnt_nxt = to_cnt + 16'd1;
        end
      end
      ERR: state_nxt = RECOVER;
      RECOVER: begin
        if (!own_cyc) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_data_out = '0;
    m0_ack     = 1'b0;
    m0_err     = 1'b0;
    m0_stall   = 1'b1;
    m0_data_in = '0;
    m1_ack     = 1'b0;
    m1_err     = 1'b0;
    m1_stall   = 1'b1;
    m1_data_in = '0;
    case (state)
      GRANT0: begin
        s_cyc      = m0_cyc;
        s_stb      = m0_stb;
        s_we       = m0_we;
        s_addr     = m0_addr;
        s_data_out = m0_data_out;
        m0_ack     = s_ack;
        m0_stall   = s_stall;
        m0_data_in = s_data_in;
      end
      GRANT1: begin
        s_cyc      = m1_cyc;
        s_stb      = m1_stb;
        s_we       = m1_we;
        s_addr     = m1_addr;
        s_data_out = m1_data_out;
        m1_ack     = s_ack;
        m1_stall   = s_stall;
        m1_data_in = s_data_in;
      end
      ERR: begin
        if (last_grant) m1_err = 1'b1;
        else            m0_err = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/leiwand_rv32_wb_arbiter.md
Name: leiwand_rv32_wb_arbiter

Overview:
- Two-master, one-slave Wishbone (pipelined) arbiter. It lets the rv32 core (m0) and a second bus master (m1, e.g. loader/debug/DMA) share the SoC bus that feeds the address-decoded SRAM/ROM slaves.
- Arbitration is round-robin. A grant is held for the whole cycle (CYC-locked).
- A watchdog terminates transactions the slave never acknowledges, e.g. accesses to an unmapped address, and reports an error to the master.

Parameters:
- MEM_WIDTH, 32, data/address width.
- TIMEOUT_CYCLES, 1024, consecutive no-ack cycles before abort. Legal range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 Wishbone controls
- m0_addr, m0_data_out  in  MEM_WIDTH  master 0 address / write data
- m0_data_in  out  MEM_WIDTH  read data to master 0
- m0_ack, m0_stall, m0_err  out  1 each  master 0 responses
- m1_*  same set as m0_*, for master 1
- s_cyc, s_stb, s_we  out  1 each  to slave side (decoder)
- s_addr, s_data_out  out  MEM_WIDTH  to slave
- s_data_in  in  MEM_WIDTH  slave read data
- s_ack, s_stall  in  1 each  slave responses

Behaviour:
- Clock and reset: single clock domain (clk). Reset is asynchronous, active-high.
- Reset effects: state=IDLE, last_grant=1 (so m0 wins the first tie), timeout counter=0.
- Output values in reset/IDLE: s_cyc=0, s_stb=0, s_we=0, s_addr=0, s_data_out=0; m*_ack=0, m*_err=0, m*_stall=1, m*_data_in=0.
- States: IDLE, GRANT0, GRANT1, ERR, RECOVER. State and grant owner are registered; all muxing is combinational from state.
- IDLE transitions:
  - only m0_cyc=1 -> GRANT0
  - only m1_cyc=1 -> GRANT1
  - both -> grant the master != last_grant
  - neither -> stay IDLE
- IDLE latency: 1 cycle from request to grant. While in IDLE, requesters see stall=1.
- GRANTx pass-through:
  - s_cyc=mx_cyc; s_stb, s_we, s_addr, s_data_out from master x
  - mx_ack=s_ack, mx_stall=s_stall, mx_data_in=s_data_in
  - loser: stall=1, ack=0, err=0, data_in=0
  - last_grant<=x on entry
- GRANTx exit: when mx_cyc=0 -> IDLE. There is always one dead IDLE cycle between grants, even if the other master is waiting. A pending request from the other master is then granted on the next edge.
- Timeout counter (16 bit):
  - cleared on entry to GRANTx and on any cycle with s_ack=1
  - otherwise increments each GRANTx cycle with mx_cyc=1
  - when the counter equals TIMEOUT_CYCLES-1 and s_ack=0 -> next state ERR
  - s_ack=1 on that same cycle wins: counter clears, no error
- ERR (exactly 1 cycle): mx_err=1, mx_ack=0, mx_stall=1; s_cyc=0, s_stb=0 (slave transaction aborted). Next state RECOVER.
- RECOVER: s_cyc=0; mx_stall=1, mx_err=0. Stay until mx_cyc=0, then IDLE. The other master stays blocked during ERR/RECOVER.
- Master obligations: a granted master must not deassert cyc while it has outstanding stb-accepted requests, except after err.
- Slave-side state: the arbiter keeps no outstanding-request count. Ack routing relies only on the grant owner.
- Reset asserted mid-transaction: all outputs take their reset values immediately (asynchronously). In-flight acks are dropped.

Test Plan:
- m0 single read of 0x20400000 (m1 idle), slave acks 1 cycle after stb -> s_cyc rises 1 cycle after m0_cyc; m0_ack/m0_data_in mirror the slave; m1_stall=1 throughout.
- m0 and m1 assert cyc on the same edge after reset, each doing one access and then dropping cyc -> grant order m0, dead cycle, m1. Repeat the tie -> order m0 then m1 again, because last_grant=1 after m1's grant.
- m1 holds cyc for 5 accesses while m0 requests -> m0_stall=1 and m0_ack=0 for the whole m1 cycle. m0 is granted exactly 2 cycles after m1_cyc falls.
- TIMEOUT_CYCLES=8, m0 strobes unmapped 0x00000000, slave never acks -> m0_err=1 for exactly 1 cycle, 8 cycles after grant; s_cyc=0 from that cycle on. The arbiter stays in RECOVER until m0_cyc=0, then m1 can be granted.
- TIMEOUT_CYCLES=8, s_ack arrives on the 8th no-ack cycle -> m0_ack=1, m0_err never asserts, the counter restarts.
- reset pulsed while GRANT1 is active mid-burst -> s_cyc=0, m1_ack=0 and m1_stall=1 within the same cycle. After release, a tie grants m0 first.
